inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Parametrised successor to the single-cycle PC/ROM fetch path of the openmips core.
- Generates instruction ROM addresses and absorbs ROM read latency through an in-flight tracker.
- Buffers fetched words in a prefetch queue and hands them to decode with a valid/ready handshake.
- Supports branch redirect with full flush, so it can feed a stalling, pipelined decode stage.

Parameters:
- ADDR_W, 32, PC and ROM address width.
- DATA_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset (word aligned).
- ROM_LAT, 1, ROM read latency in cycles; legal values 1..3.
- FQ_DEPTH, 4, prefetch queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 sampled at a rising clk edge resets the block.
- rom_data_i  in  DATA_W  ROM read data, valid ROM_LAT cycles after the matching rom_ce_o.
- rom_addr_o  out  ADDR_W  ROM address; equals the PC register.
- rom_ce_o  out  1  ROM read enable; a fetch is issued in every cycle it is 1.
- inst_o  out  DATA_W  queue head instruction; 0 when inst_valid_o==0.
- inst_pc_o  out  ADDR_W  PC of the queue head; 0 when inst_valid_o==0.
- inst_valid_o  out  1  queue non-empty.
- inst_ready_i  in  1  decode accepts the head this cycle.
- branch_flag_i  in  1  redirect request.
- branch_target_i  in  ADDR_W  redirect address; bits [1:0] are forced to 0.
- fq_count_o  out  clog2(FQ_DEPTH+1)  current queue occupancy.

Behaviour:
- Reset state: PC=RESET_PC, queue empty, in-flight tracker cleared.
- Outputs while rst==0: rom_ce_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, fq_count_o=0.
- Credit: inflight is the count of valid entries in a ROM_LAT-deep issue shift register; each entry holds a valid bit and the issued PC.
- Issue (combinational): rom_ce_o = rst & ~branch_flag_i & (fq_count + inflight < FQ_DEPTH).
- On issue: PC <= PC+4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0). The shift register input takes {1, PC}.
- No issue: the shift register input takes {0, x}.
- Return: when the shift register output is valid, {rom_data_i, tagged PC} is written into the queue at the end of that cycle.
- Issue in cycle t gives data in cycle t+ROM_LAT and inst_valid_o in cycle t+ROM_LAT+1. There is no bypass.
- Occupancy plus inflight never exceeds FQ_DEPTH, so a return always finds space; overflow is impossible by construction.
- Consume: inst_valid_o & inst_ready_i pops the head at the edge. A pop and a write in the same cycle leave the count unchanged.
- Sustained throughput is 1 instruction/cycle while ready is held high, if FQ_DEPTH >= ROM_LAT+2. Smaller depths are functionally correct at reduced rate.
- Empty queue: inst_valid_o=0 and inst_ready_i is ignored.
- Full queue (count==FQ_DEPTH): rom_ce_o=0 and PC holds.
- Branch (branch_flag_i=1 at an edge):
  - PC <= {branch_target_i[ADDR_W-1:2], 2'b00}.
  - Queue is emptied; any same-cycle pop or return write is discarded.
  - All shift register valid bits are cleared, so in-flight data is dropped.
  - rom_ce_o=0 in the branch cycle; fetch of the target starts the next cycle.
- Back-to-back branches: the last one wins.
- Reset mid-operation: it overrides branch, pop and return; all state returns to reset values in one edge.
- inst_o and inst_pc_o are driven from queue storage (registered), with no combinational path from rom_data_i.

Test Plan:
- Reset release, ROM_LAT=1, FQ_DEPTH=4, ready=1, ROM returns addr+0x100 -> rom_ce_o=1 from cycle 0 with addresses 0,4,8,...; inst_valid_o rises in cycle 2 with inst_pc_o=0, inst_o=0x100; then one instruction per cycle, PCs consecutive.
- ready=0 held from reset -> exactly 4 issues, fq_count_o reaches 4, rom_ce_o stays 0 and rom_addr_o=0x10. Set ready=1 -> head pc 0 accepted, issue resumes next cycle.
- Branch to 0x203 while the queue holds 3 entries and 1 is in flight -> next cycle fq_count_o=0 and rom_addr_o=0x200. First valid inst_pc_o=0x200; no word from the old stream ever appears.
- ROM_LAT=3, FQ_DEPTH=8, ready=1 -> first valid 4 cycles after the first issue; steady state 1/cycle; inflight never exceeds 3.
- PC at 0xFFFFFFF8, ready=1 -> returned PC sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Pull rst low with the queue and pipeline partially full, branch_flag_i=1 in the same cycle -> next cycle all outputs are 0 and rom_addr_o=RESET_PC. After release, fetch restarts from RESET_PC.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: ROM request/return, decode handshake, branch redirect and occupancy.
// The master modport is the fetch unit; the slave modport is its environment.
interface inst_fetch_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int FQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  logic [DATA_W-1:0] rom_data_i;
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_ce_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic [CNT_W-1:0]  fq_count_o;

  modport master (
    input  rom_data_i, inst_ready_i, branch_flag_i, branch_target_i,
    output rom_addr_o, rom_ce_o, inst_o, inst_pc_o, inst_valid_o, fq_count_o
  );

  modport slave (
    output rom_data_i, inst_ready_i, branch_flag_i, branch_target_i,
    input  rom_addr_o, rom_ce_o, inst_o, inst_pc_o, inst_valid_o, fq_count_o
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC generation, ROM latency tracking via an issue shift register,
// prefetch queue with valid/ready hand-off to decode, and branch redirect with full flush.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                ROM_LAT  = 1,
  parameter int                FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  inst_fetch_if.master    bus
);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int IFL_W = $clog2(ROM_LAT + 1);
  localparam int SUM_W = CNT_W + IFL_W + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ROM_LAT-1:0] sr_vld_q, sr_vld_d;
  logic [ADDR_W-1:0]  sr_pc_q [ROM_LAT];
  logic [DATA_W-1:0]  fq_data_q [FQ_DEPTH];
  logic [ADDR_W-1:0]  fq_pc_q [FQ_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [IFL_W-1:0]   inflight;
  logic               credit_ok;
  logic               issue;
  logic               ret;
  logic               head_vld;
  logic               pop;
  logic               wr_en;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + IFL_W'(sr_vld_q[i]);
    end
  end

  // Queue slots are reserved at issue time, so a returning word always has room.
  assign credit_ok = (SUM_W'(count_q) + SUM_W'(inflight)) < SUM_W'(FQ_DEPTH);
  assign issue     = rst & ~bus.branch_flag_i & credit_ok;
  assign ret       = sr_vld_q[ROM_LAT-1];
  assign head_vld  = rst & (count_q != '0);
  assign pop       = head_vld & bus.inst_ready_i & ~bus.branch_flag_i;
  assign wr_en     = rst & ~bus.branch_flag_i & ret;

  always_comb begin
    pc_d     = pc_q;
    sr_vld_d = (sr_vld_q << 1) | ROM_LAT'(issue);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.branch_flag_i) begin
      pc_d     = bus.branch_target_i & ~ADDR_W'(3);
      sr_vld_d = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) pc_d = pc_q + ADDR_W'(4);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (ret)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (ret && !pop)      count_d = count_q + CNT_W'(1);
      else if (!ret && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      sr_vld_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      sr_vld_q <= sr_vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage carries no reset; the valid bits and count qualify it.
  always_ff @(posedge clk) begin
    sr_pc_q[0] <= pc_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      sr_pc_q[i] <= sr_pc_q[i-1];
    end
    if (wr_en) begin
      fq_data_q[wr_ptr_q] <= bus.rom_data_i;
      fq_pc_q[wr_ptr_q]   <= sr_pc_q[ROM_LAT-1];
    end
  end

  assign bus.rom_addr_o   = pc_q;
  assign bus.rom_ce_o     = issue;
  assign bus.inst_valid_o = head_vld;
  assign bus.inst_o       = head_vld ? fq_data_q[rd_ptr_q] : '0;
  assign bus.inst_pc_o    = head_vld ? fq_pc_q[rd_ptr_q] : '0;
  assign bus.fq_count_o   = rst ? count_q : '0;
endmodule
